// File: rtl/ponteh_seq.sv
// rtl/ponteh_seq.sv - command sequencer driving the ponteh RGT/VLR configuration bus
//
// Turns high-level motor commands into ordered register writes on the ponteh
// configuration bus. A direction reversal is preceded by a stop and a dead
// time, and duty increases are applied one code at a time as a soft-start ramp.
//
// Parameters
//   DEAD_CYC  idle bus cycles after a stop write before a new direction (1..255)
//   RAMP_CYC  idle bus cycles held at each duty step during a ramp (1..255)
// Ports
//   CLK, RST                  configuration clock, synchronous active-high reset
//   E_STOP                    emergency stop, highest priority
//   CMD_VLD/CMD_RDY           command handshake
//   CMD_DIR/CMD_DIV/CMD_CMO   target direction, divider code, duty code
//   RGT, VLR                  register select / value to ponteh (RGT=11: no write)
//   BUSY                      a sequence is in progress
//   CUR_DIR/CUR_DIV/CUR_CMO   shadows of the last values written to OPE/DIV/CMO
module ponteh_seq #(
    parameter int DEAD_CYC = 16,
    parameter int RAMP_CYC = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       E_STOP,
    input  logic       CMD_VLD,
    output logic       CMD_RDY,
    input  logic [1:0] CMD_DIR,
    input  logic [1:0] CMD_DIV,
    input  logic [1:0] CMD_CMO,
    output logic [1:0] RGT,
    output logic [1:0] VLR,
    output logic       BUSY,
    output logic [1:0] CUR_DIR,
    output logic [1:0] CUR_DIV,
    output logic [1:0] CUR_CMO
);

    localparam logic [1:0] REG_OPE  = 2'b00;
    localparam logic [1:0] REG_DIV  = 2'b01;
    localparam logic [1:0] REG_CMO  = 2'b10;
    localparam logic [1:0] REG_NONE = 2'b11;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC - 1);
    localparam logic [7:0] RAMP_LOAD = 8'(RAMP_CYC - 1);

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_RUN,
        S_STOP_W,
        S_DEAD,
        S_CFG_DIV,
        S_CFG_CMO0,
        S_START,
        S_RAMP_WAIT,
        S_RAMP_STEP,
        S_ADJ
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] tgt_dir, tgt_div, tgt_cmo;
    logic [1:0] tgt_dir_nxt, tgt_div_nxt, tgt_cmo_nxt;
    logic       wr_en;
    logic [1:0] wr_reg, wr_val;
    logic       accept;
    logic [1:0] cmd_dir_eff;
    logic       rdy_nxt;

    // Direction code 11 is a synonym for stop.
    assign cmd_dir_eff = (CMD_DIR == 2'b11) ? 2'b00 : CMD_DIR;
    // CMD_RDY is registered, so a same-cycle E_STOP must still block the transfer.
    assign accept      = CMD_VLD && CMD_RDY && !E_STOP;

    function automatic logic settled(input state_t s);
        return (s == S_IDLE) || (s == S_RUN);
    endfunction

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tgt_dir_nxt = tgt_dir;
        tgt_div_nxt = tgt_div;
        tgt_cmo_nxt = tgt_cmo;
        wr_en       = 1'b0;
        wr_reg      = REG_NONE;
        wr_val      = 2'b00;

        if (state != S_INIT && E_STOP) begin
            tgt_dir_nxt = 2'b00;
            if (state == S_DEAD) begin
                cnt_nxt = DEAD_LOAD;
            end else if (state != S_IDLE) begin
                // IDLE already has OPE=00, so a held stop simply parks there.
                state_nxt = S_STOP_W;
            end
        end else begin
            case (state)
                S_INIT: begin
                    wr_en  = 1'b1;
                    wr_val = 2'b00;
                    case (cnt[1:0])
                        2'd0:    wr_reg = REG_OPE;
                        2'd1:    wr_reg = REG_DIV;
                        default: wr_reg = REG_CMO;
                    endcase
                    if (cnt[1:0] == 2'd2) begin
                        cnt_nxt   = 8'd0;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        tgt_dir_nxt = cmd_dir_eff;
                        tgt_div_nxt = CMD_DIV;
                        tgt_cmo_nxt = CMD_CMO;
                        if (cmd_dir_eff != 2'b00) begin
                            state_nxt = S_CFG_DIV;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        tgt_dir_nxt = cmd_dir_eff;
                        tgt_div_nxt = CMD_DIV;
                        tgt_cmo_nxt = CMD_CMO;
                        if (cmd_dir_eff != CUR_DIR) begin
                            state_nxt = S_STOP_W;
                        end else if (CMD_DIV != CUR_DIV || CMD_CMO != CUR_CMO) begin
                            state_nxt = S_ADJ;
                        end
                    end
                end
                S_STOP_W: begin
                    wr_en     = 1'b1;
                    wr_reg    = REG_OPE;
                    wr_val    = 2'b00;
                    cnt_nxt   = DEAD_LOAD;
                    state_nxt = S_DEAD;
                end
                S_DEAD: begin
                    if (cnt == 8'd0) begin
                        state_nxt = (tgt_dir == 2'b00) ? S_IDLE : S_CFG_DIV;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_CFG_DIV: begin
                    wr_en     = 1'b1;
                    wr_reg    = REG_DIV;
                    wr_val    = tgt_div;
                    state_nxt = S_CFG_CMO0;
                end
                S_CFG_CMO0: begin
                    // Start at the lowest duty; the ramp climbs to the target.
                    wr_en     = 1'b1;
                    wr_reg    = REG_CMO;
                    wr_val    = 2'b00;
                    state_nxt = S_START;
                end
                S_START: begin
                    wr_en  = 1'b1;
                    wr_reg = REG_OPE;
                    wr_val = tgt_dir;
                    if (tgt_cmo == 2'b00) begin
                        state_nxt = S_RUN;
                    end else begin
                        cnt_nxt   = RAMP_LOAD;
                        state_nxt = S_RAMP_WAIT;
                    end
                end
                S_RAMP_WAIT: begin
                    if (cnt == 8'd0) begin
                        state_nxt = S_RAMP_STEP;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_RAMP_STEP: begin
                    if (CUR_CMO >= tgt_cmo) begin
                        state_nxt = S_RUN;
                    end else begin
                        wr_en  = 1'b1;
                        wr_reg = REG_CMO;
                        wr_val = CUR_CMO + 2'd1;
                        if (CUR_CMO + 2'd1 == tgt_cmo) begin
                            state_nxt = S_RUN;
                        end else begin
                            cnt_nxt   = RAMP_LOAD;
                            state_nxt = S_RAMP_WAIT;
                        end
                    end
                end
                S_ADJ: begin
                    // DIV first (staying here), then the duty on a later pass.
                    if (tgt_div != CUR_DIV) begin
                        wr_en  = 1'b1;
                        wr_reg = REG_DIV;
                        wr_val = tgt_div;
                    end else if (tgt_cmo < CUR_CMO) begin
                        wr_en     = 1'b1;
                        wr_reg    = REG_CMO;
                        wr_val    = tgt_cmo;
                        state_nxt = S_RUN;
                    end else if (tgt_cmo > CUR_CMO) begin
                        cnt_nxt   = RAMP_LOAD;
                        state_nxt = S_RAMP_WAIT;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_INIT;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Ready is withheld for the settling cycle right after a sequence ends.
    assign rdy_nxt = settled(state) && settled(state_nxt) && !E_STOP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_INIT;
            cnt     <= 8'd0;
            tgt_dir <= 2'b00;
            tgt_div <= 2'b00;
            tgt_cmo <= 2'b00;
            RGT     <= REG_NONE;
            VLR     <= 2'b00;
            CMD_RDY <= 1'b0;
            BUSY    <= 1'b1;
            CUR_DIR <= 2'b00;
            CUR_DIV <= 2'b00;
            CUR_CMO <= 2'b00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tgt_dir <= tgt_dir_nxt;
            tgt_div <= tgt_div_nxt;
            tgt_cmo <= tgt_cmo_nxt;
            RGT     <= wr_en ? wr_reg : REG_NONE;
            VLR     <= wr_en ? wr_val : 2'b00;
            CMD_RDY <= rdy_nxt;
            BUSY    <= !settled(state_nxt);
            if (wr_en) begin
                case (wr_reg)
                    REG_OPE: CUR_DIR <= wr_val;
                    REG_DIV: CUR_DIV <= wr_val;
                    REG_CMO: CUR_CMO <= wr_val;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ponteh_seq.sv
// tb/tb_ponteh_seq.sv - self-checking bench for ponteh_seq
module tb_ponteh_seq;

    localparam int DEAD = 3;
    localparam int RAMP = 4;
    localparam logic [3:0] BUS_IDLE = 4'b1100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       e_stop = 1'b0;
    logic       cmd_vld = 1'b0;
    logic       cmd_rdy;
    logic [1:0] cmd_dir = 2'b00, cmd_div = 2'b00, cmd_cmo = 2'b00;
    logic [1:0] rgt, vlr;
    logic       busy;
    logic [1:0] cur_dir, cur_div, cur_cmo;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected bus trace, one {RGT,VLR} entry per cycle after acceptance.
    logic [3:0] exp_q[$];
    logic [1:0] m_dir = 2'b00, m_div = 2'b00, m_cmo = 2'b00;

    ponteh_seq #(.DEAD_CYC(DEAD), .RAMP_CYC(RAMP)) dut (
        .CLK(clk), .RST(rst), .E_STOP(e_stop), .CMD_VLD(cmd_vld), .CMD_RDY(cmd_rdy),
        .CMD_DIR(cmd_dir), .CMD_DIV(cmd_div), .CMD_CMO(cmd_cmo),
        .RGT(rgt), .VLR(vlr), .BUSY(busy),
        .CUR_DIR(cur_dir), .CUR_DIV(cur_div), .CUR_CMO(cur_cmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_ramp(input logic [1:0] from, input logic [1:0] to);
        for (int v = int'(from) + 1; v <= int'(to); v++) begin
            repeat (RAMP) exp_q.push_back(BUS_IDLE);
            exp_q.push_back({2'b10, 2'(v)});
        end
    endtask

    task automatic model_start(input logic [1:0] d, input logic [1:0] dv, input logic [1:0] c);
        exp_q.push_back({2'b01, dv});
        exp_q.push_back({2'b10, 2'b00});
        exp_q.push_back({2'b00, d});
        model_ramp(2'b00, c);
    endtask

    // Expected bus activity for a command, from the current motor state.
    task automatic model_cmd(input logic [1:0] d_in, input logic [1:0] dv, input logic [1:0] c);
        logic [1:0] d;
        d = (d_in == 2'b11) ? 2'b00 : d_in;
        if (m_dir == 2'b00) begin
            if (d != 2'b00) model_start(d, dv, c);
        end else if (d != m_dir) begin
            exp_q.push_back({2'b00, 2'b00});
            repeat (DEAD) exp_q.push_back(BUS_IDLE);
            if (d != 2'b00) model_start(d, dv, c);
        end else begin
            if (dv != m_div) exp_q.push_back({2'b01, dv});
            if (c < m_cmo) begin
                exp_q.push_back({2'b10, c});
            end else if (c > m_cmo) begin
                exp_q.push_back(BUS_IDLE);
                model_ramp(m_cmo, c);
            end else if (dv != m_div) begin
                exp_q.push_back(BUS_IDLE);
            end
        end
        if (d != 2'b00) begin
            m_div = dv;
            m_cmo = c;
        end
        m_dir = d;
    endtask

    task automatic check_trace(output int writes);
        int last;
        writes = 0;
        last = exp_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (i == last) cmd_vld = 1'b0;
            check("bus", {rgt, vlr}, exp_q[i]);
            check("rdy_low", 4'(cmd_rdy), 4'd0);
            check("busy", 4'(busy), (i == last) ? 4'd0 : 4'd1);
            if (rgt != 2'b11) writes++;
            case (exp_q[i][3:2])
                2'b00: check("shadow_dir", 4'(cur_dir), 4'(exp_q[i][1:0]));
                2'b01: check("shadow_div", 4'(cur_div), 4'(exp_q[i][1:0]));
                2'b10: check("shadow_cmo", 4'(cur_cmo), 4'(exp_q[i][1:0]));
                default: ;
            endcase
        end
        @(negedge clk);
        check("rdy_high", 4'(cmd_rdy), 4'd1);
        check("bus_after", {rgt, vlr}, BUS_IDLE);
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", 4'(cmd_rdy), 4'd1);
    endtask

    task automatic send_cmd(input logic [1:0] d, input logic [1:0] dv, input logic [1:0] c,
                            output int writes);
        writes = 0;
        wait_rdy();
        cmd_dir = d; cmd_div = dv; cmd_cmo = c; cmd_vld = 1'b1;
        exp_q.delete();
        model_cmd(d, dv, c);
        @(negedge clk);
        cmd_vld = 1'b0;
        check("accept_bus_idle", {rgt, vlr}, BUS_IDLE);
        if (exp_q.size() == 0) begin
            check("noop_rdy", 4'(cmd_rdy), 4'd1);
            check("noop_busy", 4'(busy), 4'd0);
            @(negedge clk);
            check("noop_bus", {rgt, vlr}, BUS_IDLE);
        end else begin
            check("seq_busy", 4'(busy), 4'd1);
            check_trace(writes);
        end
    endtask

    task automatic check_reset_state();
        check("rst_bus", {rgt, vlr}, BUS_IDLE);
        check("rst_rdy", 4'(cmd_rdy), 4'd0);
        check("rst_busy", 4'(busy), 4'd1);
        check("rst_shadows", {2'b00, cur_dir | cur_div | cur_cmo}, 4'd0);
    endtask

    task automatic init_trace();
        int w;
        exp_q.delete();
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        m_dir = 2'b00; m_div = 2'b00; m_cmo = 2'b00;
        check_trace(w);
        check("init_writes", 4'(w), 4'd3);
    endtask

    typedef struct {
        logic [1:0] dir, div, cmo;
        logic [1:0] e_dir, e_div, e_cmo;
        int         e_writes;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int w;
        vecs[0] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 6}; // start + full ramp
        vecs[1] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 1}; // duty drop
        vecs[2] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 0}; // identical
        vecs[3] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 6}; // reversal
        vecs[4] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2}; // div + one step
        vecs[5] = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 1}; // div only
        vecs[6] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1}; // dir 11 = stop
        vecs[7] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 0}; // stop from idle
        vecs[8] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3}; // start at 25%

        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        init_trace();

        for (int i = 0; i < 9; i++) begin
            send_cmd(vecs[i].dir, vecs[i].div, vecs[i].cmo, w);
            check("vec_writes", 4'(w), 4'(vecs[i].e_writes));
            check("vec_dir", 4'(cur_dir), 4'(vecs[i].e_dir));
            check("vec_div", 4'(cur_div), 4'(vecs[i].e_div));
            check("vec_cmo", 4'(cur_cmo), 4'(vecs[i].e_cmo));
        end

        // Emergency stop in the middle of a ramp, with a competing command.
        wait_rdy();
        cmd_dir = 2'b01; cmd_div = 2'b00; cmd_cmo = 2'b11; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ramp_wait_idle", {rgt, vlr}, BUS_IDLE);
        end
        e_stop = 1'b1;
        cmd_dir = 2'b10; cmd_div = 2'b10; cmd_cmo = 2'b10; cmd_vld = 1'b1;
        @(negedge clk);
        e_stop = 1'b0;
        check("estop_bus_idle", {rgt, vlr}, BUS_IDLE);
        check("estop_rdy", 4'(cmd_rdy), 4'd0);
        exp_q.delete();
        exp_q.push_back(4'b0000);
        repeat (DEAD) exp_q.push_back(BUS_IDLE);
        check_trace(w);
        m_dir = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("estop_cmd_ignored", {rgt, vlr}, BUS_IDLE);
        end
        check("estop_dir", 4'(cur_dir), 4'd0);
        check("estop_cmo", 4'(cur_cmo), 4'd0);

        // Reset in the middle of a start sequence.
        wait_rdy();
        cmd_dir = 2'b10; cmd_div = 2'b01; cmd_cmo = 2'b11; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        @(negedge clk);
        check("pre_rst_div", {rgt, vlr}, 4'b0101);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        init_trace();

        // Random command stream against the model.
        for (int i = 0; i < 40; i++) begin
            send_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), w);
            check("rnd_dir", 4'(cur_dir), 4'(m_dir));
            if (m_dir != 2'b00) begin
                check("rnd_div", 4'(cur_div), 4'(m_div));
                check("rnd_cmo", 4'(cur_cmo), 4'(m_cmo));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
